if_id_queue: RTL

- Receiving end of the fetch stage's PC/instruction output.
- Small first-word-fall-through FIFO between fetch and decode that holds fetched {pc, instr} pairs.
- Drives fetch's PC-write enable as backpressure, and drops in-flight entries when a taken branch or jump flushes the pipe.
- Presents a NOP (32'h0000_0000, sll $0,$0,0) to decode whenever it holds no valid entry.

---
 rtl/if_id_queue_pkg.sv | 15 +
 rtl/if_id_queue_if.sv | 31 +++
 rtl/if_id_queue_mem.sv | 27 ++
 rtl/if_id_queue.sv | 88 ++++++++
 4 files changed

// File: rtl/if_id_queue_pkg.sv
// Shared fetch/decode pipeline definitions: NOP encoding, PC increment and
// the {pc, instr} entry type carried from fetch into decode and hazard logic.
package if_id_queue_pkg;

  localparam int DEFAULT_ADDR_W = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_INC    = 32'd4;

  typedef struct packed {
    logic [DEFAULT_ADDR_W-1:0] pc;
    logic [DEFAULT_ADDR_W-1:0] instr;
  } if_id_entry_t;

endpackage

// File: rtl/if_id_queue_if.sv
// Fetch-to-decode handshake bundle; the queue sits on the slave modport,
// the fetch/decode side (or a bench) on the master modport.
interface if_id_queue_if #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 32
);
  localparam int PTR_W = $clog2(DEPTH);

  logic              i_fetch_valid;
  logic [ADDR_W-1:0] i_fetch_pc;
  logic [ADDR_W-1:0] i_fetch_instr;
  logic              o_fetch_ready;
  logic              i_flush;
  logic              o_dec_valid;
  logic              i_dec_ready;
  logic [ADDR_W-1:0] o_dec_pc;
  logic [ADDR_W-1:0] o_dec_pc4;
  logic [ADDR_W-1:0] o_dec_instr;
  logic [PTR_W:0]    o_count;

  modport slave (
    input  i_fetch_valid, i_fetch_pc, i_fetch_instr, i_flush, i_dec_ready,
    output o_fetch_ready, o_dec_valid, o_dec_pc, o_dec_pc4, o_dec_instr, o_count
  );

  modport master (
    output i_fetch_valid, i_fetch_pc, i_fetch_instr, i_flush, i_dec_ready,
    input  o_fetch_ready, o_dec_valid, o_dec_pc, o_dec_pc4, o_dec_instr, o_count
  );

endinterface

// File: rtl/if_id_queue_mem.sv
// Entry storage for the fetch/decode queue: synchronous write, asynchronous
// read so the head is visible the cycle after it is written. No reset.
module if_id_mem #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/if_id_queue.sv
// First-word-fall-through queue between fetch and decode. Backpressures fetch
// through o_fetch_ready, drops held entries on flush, shows a NOP when empty.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = DEFAULT_ADDR_W,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic           i_clk,
  input  logic           i_rst,
  if_id_queue_if.slave   q
);

  logic [PTR_W-1:0]    wr_ptr_r;
  logic [PTR_W-1:0]    rd_ptr_r;
  logic [PTR_W:0]      count_r;
  logic                fetch_ready_s;
  logic                dec_valid_s;
  logic                push_s;
  logic                pop_s;
  logic                mem_we_s;
  logic [2*ADDR_W-1:0] rd_data_s;
  logic [ADDR_W-1:0]   head_pc_s;
  logic [ADDR_W-1:0]   head_instr_s;

  // Ready depends only on stored occupancy, so a full queue never accepts,
  // even in a cycle where decode drains the head.
  assign fetch_ready_s = (count_r != (PTR_W+1)'(DEPTH));
  assign dec_valid_s   = (count_r != (PTR_W+1)'(0));
  assign push_s        = q.i_fetch_valid & fetch_ready_s;
  assign pop_s         = dec_valid_s & q.i_dec_ready;
  assign mem_we_s      = push_s & ~q.i_flush & ~i_rst;

  if_id_mem #(
    .DEPTH (DEPTH),
    .WIDTH (2*ADDR_W)
  ) u_mem (
    .clk   (i_clk),
    .we    (mem_we_s),
    .waddr (wr_ptr_r),
    .wdata ({q.i_fetch_pc, q.i_fetch_instr}),
    .raddr (rd_ptr_r),
    .rdata (rd_data_s)
  );

  // Pointer and occupancy state; reset beats flush beats push/pop
  always_ff @(posedge i_clk) begin
    if (i_rst || q.i_flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (PTR_W+1)'(1'b1);
        2'b01:   count_r <= count_r - (PTR_W+1)'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Head gating: an empty queue presents PC 0 and a NOP to decode
  always_comb begin
    head_pc_s    = '0;
    head_instr_s = ADDR_W'(NOP_INSTR);
    if (dec_valid_s) begin
      head_pc_s    = rd_data_s[2*ADDR_W-1:ADDR_W];
      head_instr_s = rd_data_s[ADDR_W-1:0];
    end else begin
      head_pc_s    = '0;
      head_instr_s = ADDR_W'(NOP_INSTR);
    end
  end

  assign q.o_fetch_ready = fetch_ready_s;
  assign q.o_dec_valid   = dec_valid_s;
  assign q.o_dec_pc      = head_pc_s;
  assign q.o_dec_pc4     = head_pc_s + ADDR_W'(PC_INC);
  assign q.o_dec_instr   = head_instr_s;
  assign q.o_count       = count_r;

endmodule
